// File: rtl/spi_reg_burst.sv
// spi_reg_burst: SPI register-access slave (modes 0-3), command byte + REG_W-bit words, MSB first.
// Latency: 3 clk pin-to-pulse; reg_we / reg_re 1 clk after the final bit's internal sample pulse.
// Backpressure: none; SPI clock must be <= clk/8. Macro SPI_REG_BURST_EN enables burst auto-increment.
module spi_reg_burst #(
    parameter int ADDR_W = 7,
    parameter int REG_W  = 8
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic              ena,
    input  logic [1:0]        mode,
    input  logic              spi_cs_n,
    input  logic              spi_clk,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [REG_W-1:0]  reg_wdata,
    output logic              reg_we,
    output logic              reg_re,
    input  logic [REG_W-1:0]  reg_rdata,
    input  logic [7:0]        status,
    output logic              frame_err
);
    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] CMD  = 3'd1;
    localparam logic [2:0] WR   = 3'd2;
    localparam logic [2:0] RD   = 3'd3;
    localparam logic [2:0] DONE = 3'd4;

    localparam int CNT_W = $clog2(REG_W) + 1;
    localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(7);
    localparam logic [CNT_W-1:0] WORD_LAST = CNT_W'(REG_W - 1);

    logic [2:0]       cs_sync;
    logic [2:0]       sck_sync;
    logic [1:0]       mosi_sync;
    logic [2:0]       state;
    logic [1:0]       mode_q;
    logic [CNT_W-1:0] bit_cnt;
    logic [REG_W-2:0] rx_shift;
    logic [REG_W-1:0] rx_next;
    logic [REG_W-1:0] tx_shift;
    logic [REG_W-1:0] hold;
    logic             started;
    logic             load_pend;
    logic             cap_pend;
    logic             sof, eof, clk_pos, clk_neg;
    logic             sample_edge, change_edge;

    // Two-flop synchronisers plus one delay stage for edge detection. cs resets low so a
    // frame already in progress when reset releases is never mistaken for a fresh start.
    always_ff @(posedge clk) begin
        if (!rstb) begin
            cs_sync   <= '0;
            sck_sync  <= '0;
            mosi_sync <= '0;
        end else if (ena) begin
            cs_sync   <= {cs_sync[1:0], spi_cs_n};
            sck_sync  <= {sck_sync[1:0], spi_clk};
            mosi_sync <= {mosi_sync[0], spi_mosi};
        end
    end

    assign sof     =  cs_sync[2]  & ~cs_sync[1];
    assign eof     = ~cs_sync[2]  &  cs_sync[1];
    assign clk_pos = ~sck_sync[2] &  sck_sync[1];
    assign clk_neg =  sck_sync[2] & ~sck_sync[1];

    // Modes 0 and 3 sample on the rising edge, modes 1 and 2 on the falling edge.
    assign sample_edge = (mode_q[1] ^ mode_q[0]) ? clk_neg : clk_pos;
    assign change_edge = (mode_q[1] ^ mode_q[0]) ? clk_pos : clk_neg;
    assign rx_next     = {rx_shift, mosi_sync[1]};

    assign spi_miso    = (state == CMD || state == WR || state == RD) ? tx_shift[REG_W-1] : 1'b0;
    assign spi_miso_oe = (state != IDLE);

    // Frame FSM: command decode, word shifting, strobes and read-data prefetch.
    always_ff @(posedge clk) begin
        if (!rstb) begin
            state     <= IDLE;
            mode_q    <= '0;
            bit_cnt   <= '0;
            rx_shift  <= '0;
            tx_shift  <= '0;
            hold      <= '0;
            started   <= 1'b0;
            load_pend <= 1'b0;
            cap_pend  <= 1'b0;
            reg_addr  <= '0;
            reg_wdata <= '0;
            reg_we    <= 1'b0;
            reg_re    <= 1'b0;
            frame_err <= 1'b0;
        end else if (ena) begin
            reg_we    <= 1'b0;
            reg_re    <= 1'b0;
            frame_err <= 1'b0;
            // Read data is valid the cycle after reg_re; grab it then.
            cap_pend  <= reg_re;
            if (cap_pend) hold <= reg_rdata;
`ifdef SPI_REG_BURST_EN
            // Advance only after the strobe so reg_addr is stable while reg_we is high.
            if (reg_we) reg_addr <= reg_addr + ADDR_W'(1);
`endif
            if (state == IDLE) mode_q <= mode;

            if (eof) begin
                // eof wins over a coincident last-bit sample: the partial word is dropped.
                if (state == CMD || bit_cnt != '0) frame_err <= 1'b1;
                state     <= IDLE;
                bit_cnt   <= '0;
                started   <= 1'b0;
                load_pend <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (sof) begin
                            tx_shift  <= REG_W'(status) << (REG_W - 8);
                            bit_cnt   <= '0;
                            started   <= 1'b0;
                            load_pend <= 1'b0;
                            state     <= CMD;
                        end
                    end
                    CMD, WR, RD: begin
                        if (sample_edge) begin
                            started  <= 1'b1;
                            rx_shift <= rx_next[REG_W-2:0];
                            bit_cnt  <= bit_cnt + CNT_W'(1);
                            if (state == CMD && bit_cnt == CMD_LAST) begin
                                bit_cnt  <= '0;
                                reg_addr <= rx_next[ADDR_W-1:0];
                                if (rx_next[7]) begin
                                    state <= WR;
                                end else begin
                                    state     <= RD;
                                    reg_re    <= 1'b1;
                                    load_pend <= 1'b1;
                                end
                            end else if (state == WR && bit_cnt == WORD_LAST) begin
                                bit_cnt   <= '0;
                                reg_wdata <= rx_next;
                                reg_we    <= 1'b1;
`ifndef SPI_REG_BURST_EN
                                state     <= DONE;
`endif
                            end else if (state == RD && bit_cnt == WORD_LAST) begin
                                bit_cnt <= '0;
`ifdef SPI_REG_BURST_EN
                                reg_addr  <= reg_addr + ADDR_W'(1);
                                reg_re    <= 1'b1;
                                load_pend <= 1'b1;
`else
                                state     <= DONE;
`endif
                            end
                        end else if (change_edge && started) begin
                            // Change edges before the first sample (CPHA=1 lead-in) are ignored.
                            if (load_pend) begin
                                tx_shift  <= hold;
                                load_pend <= 1'b0;
                            end else begin
                                tx_shift <= {tx_shift[REG_W-2:0], 1'b0};
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_spi_reg_burst.sv
// tb_spi_reg_burst: bit-banged SPI master driving two instances (8-bit/7-bit addr and 16-bit/3-bit addr).
// Latency: each frame is followed by a settle gap before results are checked.
// Backpressure: none; SPI half period is 8 clk.
module tb_spi_reg_burst;
`ifdef SPI_REG_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif
    localparam int HALF = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstb, ena, cs0, cs1, sclk, mosi;
    logic [1:0]  mode;
    logic [7:0]  status, rdata0;
    logic [15:0] rdata1;
    logic        miso0, oe0, we0, re0, fe0;
    logic [6:0]  addr0;
    logic [7:0]  wdata0;
    logic        miso1, oe1, we1, re1, fe1;
    logic [2:0]  addr1;
    logic [15:0] wdata1;

    spi_reg_burst #(.ADDR_W(7), .REG_W(8)) u0 (
        .clk(clk), .rstb(rstb), .ena(ena), .mode(mode), .spi_cs_n(cs0), .spi_clk(sclk),
        .spi_mosi(mosi), .spi_miso(miso0), .spi_miso_oe(oe0), .reg_addr(addr0),
        .reg_wdata(wdata0), .reg_we(we0), .reg_re(re0), .reg_rdata(rdata0),
        .status(status), .frame_err(fe0));

    spi_reg_burst #(.ADDR_W(3), .REG_W(16)) u1 (
        .clk(clk), .rstb(rstb), .ena(ena), .mode(mode), .spi_cs_n(cs1), .spi_clk(sclk),
        .spi_mosi(mosi), .spi_miso(miso1), .spi_miso_oe(oe1), .reg_addr(addr1),
        .reg_wdata(wdata1), .reg_we(we1), .reg_re(re1), .reg_rdata(rdata1),
        .status(status), .frame_err(fe1));

    typedef struct {
        string       name;
        int          sel;
        logic [1:0]  mode;
        int          nbits;
        logic [63:0] mosi;
        logic [15:0] rdata;
        logic [63:0] miso;
        int          n_re;
        int          n_fe;
        int          n_we;
        logic [6:0]  a0;
        logic [15:0] d0;
        logic [6:0]  a1;
        logic [15:0] d1;
    } vec_t;

    typedef struct {
        int          sel;
        logic [6:0]  a;
        logic [15:0] d;
    } wr_t;

    wr_t         exp_q[$];
    int          n_cmp = 0;
    int          n_fail = 0;
    int          we_n[2] = '{0, 0};
    int          re_n[2] = '{0, 0};
    int          fe_n[2] = '{0, 0};
    logic [6:0]  log_a[2][64];
    logic [15:0] log_d[2][64];

    // Output monitor: logs every write strobe and counts read requests / frame errors.
    always @(negedge clk) begin
        if (we0) begin
            log_a[0][we_n[0] % 64] = addr0;
            log_d[0][we_n[0] % 64] = {8'h00, wdata0};
            we_n[0] = we_n[0] + 1;
        end
        if (we1) begin
            log_a[1][we_n[1] % 64] = {4'h0, addr1};
            log_d[1][we_n[1] % 64] = wdata1;
            we_n[1] = we_n[1] + 1;
        end
        if (re0) re_n[0] = re_n[0] + 1;
        if (re1) re_n[1] = re_n[1] + 1;
        if (fe0) fe_n[0] = fe_n[0] + 1;
        if (fe1) fe_n[1] = fe_n[1] + 1;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One complete SPI frame; optionally pulses rstb just before bit rst_at.
    task automatic spi_xfer(input int sel, input logic [1:0] m, input int nbits,
                            input logic [63:0] tx, input int rst_at,
                            output logic [63:0] rx, output logic oe_seen);
        logic cpha;
        cpha    = m[0];
        rx      = '0;
        oe_seen = 1'b0;
        mode    = m;
        sclk    = m[1];
        wait_clk(10);
        if (sel == 0) cs0 = 1'b0; else cs1 = 1'b0;
        for (int i = nbits - 1; i >= 0; i--) begin
            if (i == rst_at) begin
                rstb = 1'b0;
                wait_clk(2);
                rstb = 1'b1;
            end
            if (!cpha) mosi = tx[i];
            wait_clk(HALF);
            if (!cpha) rx = {rx[62:0], (sel == 0) ? miso0 : miso1};
            sclk = ~sclk;
            if (cpha) mosi = tx[i];
            wait_clk(HALF);
            if (cpha) rx = {rx[62:0], (sel == 0) ? miso0 : miso1};
            sclk = ~sclk;
            if (i == nbits - 4) oe_seen = (sel == 0) ? oe0 : oe1;
        end
        wait_clk(HALF);
        if (sel == 0) cs0 = 1'b1; else cs1 = 1'b1;
        wait_clk(12);
    endtask

    task automatic run_vec(input vec_t t);
        int          we_b, re_b, fe_b;
        logic [63:0] rx;
        logic        oe_s;
        wr_t         e;
        we_b = we_n[t.sel];
        re_b = re_n[t.sel];
        fe_b = fe_n[t.sel];
        if (t.n_we > 0) begin e.sel = t.sel; e.a = t.a0; e.d = t.d0; exp_q.push_back(e); end
        if (t.n_we > 1) begin e.sel = t.sel; e.a = t.a1; e.d = t.d1; exp_q.push_back(e); end
        rdata0 = t.rdata[7:0];
        rdata1 = t.rdata;
        spi_xfer(t.sel, t.mode, t.nbits, t.mosi, -1, rx, oe_s);
        check({t.name, " miso"}, rx, t.miso);
        check({t.name, " oe_active"}, 64'(oe_s), 64'd1);
        check({t.name, " re_count"}, 64'(re_n[t.sel] - re_b), 64'(t.n_re));
        check({t.name, " ferr_count"}, 64'(fe_n[t.sel] - fe_b), 64'(t.n_fe));
        check({t.name, " we_count"}, 64'(we_n[t.sel] - we_b), 64'(t.n_we));
        for (int j = 0; j < t.n_we; j++) begin
            e = exp_q.pop_front();
            check({t.name, " we_addr"}, 64'(log_a[e.sel][(we_b + j) % 64]), 64'(e.a));
            check({t.name, " we_data"}, 64'(log_d[e.sel][(we_b + j) % 64]), 64'(e.d));
        end
        check({t.name, " idle_miso_oe"}, (t.sel == 0) ? {62'd0, miso0, oe0} : {62'd0, miso1, oe1}, 64'd0);
    endtask

    initial begin
        vec_t        v[8];
        logic [63:0] rx;
        logic        oe_s;
        int          we_b, fe_b, re_b;

        v[0] = '{"wr_m0",       0, 2'd0, 16, 64'h85A5,     16'h0000, 64'h3C00,
                 0, 0, 1, 7'd5, 16'h00A5, 7'd0, 16'h0000};
        v[1] = '{"rd_m3",       0, 2'd3, 16, 64'h0200,     16'h005A, 64'h3C5A,
                 BURST ? 2 : 1, 0, 0, 7'd0, 16'h0, 7'd0, 16'h0};
        v[2] = '{"wr_wrap",     1, 2'd0, 40, 64'h87_0011_0022, 16'h0000, 64'h3C_0000_0000,
                 0, 0, BURST ? 2 : 1, 7'd7, 16'h0011, 7'd0, 16'h0022};
        v[3] = '{"rd_m1_w16",   1, 2'd1, 24, 64'h04_0000,  16'hBEEF, 64'h3C_BEEF,
                 BURST ? 2 : 1, 0, 0, 7'd0, 16'h0, 7'd0, 16'h0};
        v[4] = '{"abort",       0, 2'd0, 13, 64'h1035,     16'h0000, 64'h0780,
                 0, 1, 0, 7'd0, 16'h0, 7'd0, 16'h0};
        v[5] = '{"rd_m2_2byte", 0, 2'd2, 24, 64'h03_0000,  16'h0096,
                 BURST ? 64'h3C_9696 : 64'h3C_9600,
                 BURST ? 3 : 1, 0, 0, 7'd0, 16'h0, 7'd0, 16'h0};
        v[6] = '{"wr_m1_top",   0, 2'd1, 16, 64'hFF01,     16'h0000, 64'h3C00,
                 0, 0, 1, 7'h7F, 16'h0001, 7'd0, 16'h0};
        v[7] = '{"wr_m2_w16",   1, 2'd2, 24, 64'h82_1234,  16'h0000, 64'h3C_0000,
                 0, 0, 1, 7'd2, 16'h1234, 7'd0, 16'h0};

        rstb = 1'b0; ena = 1'b1; cs0 = 1'b1; cs1 = 1'b1; sclk = 1'b0; mosi = 1'b0;
        mode = 2'd0; status = 8'h3C; rdata0 = '0; rdata1 = '0;
        wait_clk(5);
        check("reset_outs_u0", {45'd0, miso0, oe0, addr0, wdata0, we0, re0, fe0}, 64'd0);
        check("reset_outs_u1", {36'd0, miso1, oe1, addr1, wdata1, we1, re1, fe1}, 64'd0);
        rstb = 1'b1;
        wait_clk(5);

        for (int k = 0; k < 8; k++) run_vec(v[k]);

        // ena low: the whole frame must be invisible to the slave.
        we_b = we_n[0]; fe_b = fe_n[0]; re_b = re_n[0];
        ena = 1'b0;
        spi_xfer(0, 2'd0, 16, 64'h85A5, -1, rx, oe_s);
        ena = 1'b1;
        wait_clk(10);
        check("ena_low oe", 64'(oe_s), 64'd0);
        check("ena_low we_count", 64'(we_n[0] - we_b), 64'd0);
        check("ena_low ferr_count", 64'(fe_n[0] - fe_b), 64'd0);
        check("ena_low re_count", 64'(re_n[0] - re_b), 64'd0);

        // Reset in the middle of the data word: rest of the frame ignored, no strobe, no error.
        we_b = we_n[0]; fe_b = fe_n[0];
        spi_xfer(0, 2'd0, 16, 64'h85A5, 6, rx, oe_s);
        check("rst_mid we_count", 64'(we_n[0] - we_b), 64'd0);
        check("rst_mid ferr_count", 64'(fe_n[0] - fe_b), 64'd0);
        check("rst_mid addr", 64'(addr0), 64'd0);

        // A fresh frame after the mid-frame reset works normally.
        run_vec(v[0]);

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
